// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared defaults and FSM state type for the SPI slave receiver
package spi_pkg;

    localparam int DATA_W_DEF     = 12;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// rtl/spi_slave_rx_if.sv - SPI wire side plus received-word handshake and status
interface spi_slave_rx_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              frame_err;
    logic              overflow;

    modport slave (
        input  sclk, cs, mosi, dout_ready,
        output dout, dout_valid, busy, frame_err, overflow
    );

    modport master (
        output sclk, cs, mosi, dout_ready,
        input  dout, dout_valid, busy, frame_err, overflow
    );

endinterface

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - first-word fall-through buffer for received words
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              overflow_q;
    logic              do_push;
    logic              do_pop;

    assign full_o     = (cnt_q == CW'(FIFO_DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign dout_o     = mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

    // A pop frees the slot that a same-cycle push into a full buffer needs.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next pointer/occupancy values; power-of-2 depth makes pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // Storage, pointers and the registered drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= push_i & full_o & ~do_pop;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave receiver: synchronizers, framing FSM, word buffer
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_rx_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W);

    logic              cs_meta_q, cs_sync_q, cs_high_q;
    logic              sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic              mosi_meta_q, mosi_sync_q;
    logic [1:0]        vld_q;
    logic              cs_fall;
    logic              sclk_fall;

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] word_q;
    logic              push_q;
    logic              frame_err_q;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_ovf;

    // Two-flop synchronizers; vld_q marks when cs_sync_q holds a real post-reset
    // sample so a cs held low through reset cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_high_q   <= 1'b0;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            vld_q       <= 2'b00;
        end else begin
            cs_meta_q   <= bus.cs;
            cs_sync_q   <= cs_meta_q;
            cs_high_q   <= vld_q[1] & cs_sync_q;
            sclk_meta_q <= bus.sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= bus.mosi;
            mosi_sync_q <= mosi_meta_q;
            vld_q       <= {vld_q[0], 1'b1};
        end
    end

    assign cs_fall   = cs_high_q & ~cs_sync_q;
    assign sclk_fall = sclk_prev_q & ~sclk_sync_q;

    // Framing FSM: dummy first falling edge, LSB-first shift, push on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            word_q      <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= SKIP;
                        count_q <= '0;
                        word_q  <= '0;
                    end
                end
                SKIP: begin
                    if (cs_sync_q) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end else if (sclk_fall) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_sync_q) begin
                        state_q     <= IDLE;
                        count_q     <= '0;
                        frame_err_q <= 1'b1;
                    end else if (sclk_fall) begin
                        word_q[count_q] <= mosi_sync_q;
                        if (count_q == CNT_W'(DATA_W - 1)) begin
                            state_q <= DONE;
                            count_q <= '0;
                            push_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (cs_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    spi_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_q),
        .din_i      (word_q),
        .pop_i      (bus.dout_ready),
        .dout_o     (fifo_dout),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    assign bus.dout       = fifo_dout;
    assign bus.dout_valid = ~fifo_empty;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = fifo_ovf;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - randomized self-checking bench with a queue-based reference model
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int DW    = 12;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_rx_if #(.DATA_W(DW)) bus ();

    spi_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: expected buffer contents plus scheduled events
    logic [DW-1:0] mq [$];
    int            push_cyc_q [$];
    logic [DW-1:0] push_word_q [$];
    int            ferr_sched = -1;
    int            busy_on    = -1;
    int            busy_off   = -1;
    bit            busy_m     = 1'b0;
    bit            ovf_m      = 1'b0;

    int            ferr_cnt = 0;
    int            ovf_cnt  = 0;
    int            vld_cnt  = 0;
    logic [DW-1:0] popped [$];
    bit            prev_valid = 1'b0;
    logic [DW-1:0] prev_dout  = '0;

    int rdy_mode  = 0;
    int rdy_pulse = -1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_popped(string name, logic [DW-1:0] exp [$]);
        chk({name, "_count"}, popped.size(), exp.size());
        for (int i = 0; i < exp.size() && i < popped.size(); i++) begin
            chk(name, popped[i], exp[i]);
        end
    endtask

    // Advance the model one clock and compare every DUT output
    initial begin : cmp
        bit pop_m;
        bit push_m;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst && prev_valid && bus.dout_ready) popped.push_back(prev_dout);
            if (rst) begin
                mq.delete();
                push_cyc_q.delete();
                push_word_q.delete();
                ferr_sched = -1;
                busy_on    = -1;
                busy_off   = -1;
                busy_m     = 1'b0;
                ovf_m      = 1'b0;
            end else begin
                pop_m  = (mq.size() > 0) && bus.dout_ready;
                push_m = (push_cyc_q.size() > 0) && (push_cyc_q[0] == cyc);
                ovf_m  = push_m && (mq.size() == DEPTH) && !pop_m;
                if (pop_m) void'(mq.pop_front());
                if (push_m) begin
                    if (!ovf_m) mq.push_back(push_word_q[0]);
                    void'(push_cyc_q.pop_front());
                    void'(push_word_q.pop_front());
                end
                if (cyc == busy_on)  busy_m = 1'b1;
                if (cyc == busy_off) busy_m = 1'b0;
            end
            chk("dout_valid", bus.dout_valid, mq.size() > 0);
            if (mq.size() > 0) chk("dout", bus.dout, mq[0]);
            else if (rst) chk("dout_rst", bus.dout, 0);
            chk("overflow", bus.overflow, ovf_m);
            chk("frame_err", bus.frame_err, cyc == ferr_sched);
            chk("busy", bus.busy, busy_m);
            ferr_cnt += int'(bus.frame_err);
            ovf_cnt  += int'(bus.overflow);
            vld_cnt  += int'(bus.dout_valid);
            prev_valid = bus.dout_valid;
            prev_dout  = bus.dout;
        end
    end

    // Consumer-ready driver
    initial begin
        bus.dout_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.dout_ready = 1'b0;
                1:       bus.dout_ready = 1'b1;
                2:       bus.dout_ready = 1'($urandom_range(0, 1));
                default: bus.dout_ready = (cyc == rdy_pulse);
            endcase
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tk(int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame: dummy falling edge, then nbits data bits LSB first.
    // An edge driven at the negedge after cycle k is seen by the FSM at k+3
    // (two synchronizer flops plus edge detection); the word lands at k+4.
    task automatic frame(logic [DW-1:0] w, int nbits, int hp, bit rst_abort);
        bus.cs  = 1'b0;
        busy_on = cyc + 3;
        tk(hp);
        bus.sclk = 1'b1; tk(hp);
        bus.sclk = 1'b0; tk(hp);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = w[i];
            bus.sclk = 1'b1;
            tk(hp);
            bus.sclk = 1'b0;
            if (i == DW - 1) begin
                push_cyc_q.push_back(cyc + 4);
                push_word_q.push_back(w);
                rdy_pulse = cyc + 3;
            end
            tk(hp);
        end
        if (rst_abort) begin
            rst = 1'b1; tk(2);
            rst = 1'b0; tk(8);
            bus.cs = 1'b1; tk(8);
        end else begin
            bus.cs   = 1'b1;
            busy_off = cyc + 3;
            if (nbits < DW) ferr_sched = cyc + 3;
            tk(hp + 4);
        end
    endtask

    initial begin : stim
        logic [DW-1:0] e [$];
        logic [DW-1:0] w [5];
        int e0, o0, v0, nb;

        rst = 1'b1; bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        tk(4);
        chk("rst_dout", bus.dout, 0);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst = 1'b0;
        tk(4);

        // single frame, consumer always ready
        rdy_mode = 1; tk(2);
        popped.delete(); v0 = vld_cnt; e0 = ferr_cnt;
        frame(12'hA5C, DW, 4, 1'b0);
        tk(4);
        chk("a5c_valid_cycles", vld_cnt - v0, 1);
        chk("a5c_ferr", ferr_cnt - e0, 0);
        e = {12'hA5C};
        chk_popped("a5c_word", e);

        // back-to-back frames
        popped.delete(); o0 = ovf_cnt;
        frame(12'h001, DW, 4, 1'b0);
        frame(12'h800, DW, 4, 1'b0);
        frame(12'hFFF, DW, 4, 1'b0);
        tk(4);
        e = {12'h001, 12'h800, 12'hFFF};
        chk_popped("b2b_order", e);
        chk("b2b_ovf", ovf_cnt - o0, 0);

        // aborted frame, then a clean one
        popped.delete(); e0 = ferr_cnt;
        frame(DW'($urandom), 5, 5, 1'b0);
        frame(12'h3C3, DW, 4, 1'b0);
        tk(4);
        chk("abort_ferr_pulses", ferr_cnt - e0, 1);
        e = {12'h3C3};
        chk_popped("abort_next", e);

        // five frames into a four-entry buffer with no consumer
        rdy_mode = 0; tk(2);
        popped.delete(); o0 = ovf_cnt;
        for (int i = 0; i < 5; i++) w[i] = DW'($urandom);
        for (int i = 0; i < 5; i++) frame(w[i], DW, 4, 1'b0);
        tk(4);
        chk("full_ovf_pulses", ovf_cnt - o0, 1);
        chk("full_valid", bus.dout_valid, 1);
        chk("full_head", bus.dout, w[0]);
        rdy_mode = 1; tk(10);
        e = {w[0], w[1], w[2], w[3]};
        chk_popped("full_drain", e);

        // full buffer, push coinciding with a single pop
        rdy_mode = 0; tk(2);
        popped.delete(); o0 = ovf_cnt;
        for (int i = 0; i < 5; i++) w[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) frame(w[i], DW, 4, 1'b0);
        rdy_mode = 3;
        frame(w[4], DW, 4, 1'b0);
        rdy_mode = 0; tk(2);
        chk("pp_ovf", ovf_cnt - o0, 0);
        chk("pp_valid", bus.dout_valid, 1);
        chk("pp_head", bus.dout, w[1]);
        rdy_mode = 1; tk(10);
        e = {w[0], w[1], w[2], w[3], w[4]};
        chk_popped("pp_order", e);

        // reset mid-frame with a word buffered, then a clean frame
        rdy_mode = 0; tk(2);
        frame(DW'($urandom), DW, 4, 1'b0);
        popped.delete(); e0 = ferr_cnt;
        frame(DW'($urandom), 6, 4, 1'b1);
        chk("rstmid_valid", bus.dout_valid, 0);
        chk("rstmid_dout", bus.dout, 0);
        chk("rstmid_busy", bus.busy, 0);
        frame(12'h5A5, DW, 4, 1'b0);
        rdy_mode = 1; tk(8);
        chk("rstmid_ferr", ferr_cnt - e0, 0);
        e = {12'h5A5};
        chk_popped("rstmid_word", e);

        // randomized frames, random consumer, varying sclk rate and aborts
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 1)) : DW;
            frame(DW'($urandom), nb, int'($urandom_range(4, 7)), 1'b0);
        end
        rdy_mode = 1; tk(20);
        chk("rand_drained", bus.dout_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 12, frame length in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, received-word buffer entries (power of 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-006 SHALL have port cs  input  1  chip select, active-low, asynchronous.
REQ-007 SHALL have port mosi  input  1  serial data, asynchronous.
REQ-008 SHALL have port dout  output  DATA_W  head-of-buffer received word.
REQ-009 SHALL have port dout_valid  output  1  buffer non-empty; dout is valid.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on an aborted frame.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-014 SHALL pass sclk, cs and mosi through 2-flop synchronizers; edge detection SHALL use the synchronized values.
REQ-015 SHALL support sclk half-period >= 4 clk cycles; shorter periods are out of spec.
REQ-016 SHALL implement FSM states IDLE, SKIP, SHIFT and DONE.
REQ-017 IDLE->SKIP on a synchronized cs falling edge (high-to-low); cs observed low without a preceding high SHALL NOT start a frame.
REQ-018 SKIP: the first sclk falling edge after cs assertion carries no data and SHALL be ignored; SKIP->SHIFT on that edge.
REQ-019 SHIFT: on each sclk falling edge SHALL capture mosi into bit position count (LSB first, count 0..DATA_W-1) and increment count.
REQ-020 SHIFT->DONE in the cycle bit DATA_W-1 is captured; the assembled word SHALL be pushed to the buffer on the next clk cycle.
REQ-021 DONE: further sclk edges SHALL be ignored; DONE->IDLE on synchronized cs high.
REQ-022 cs going high in SKIP or SHIFT SHALL discard the partial word, pulse frame_err for one cycle and return to IDLE.
REQ-023 sclk rising edges SHALL be ignored in all states.
REQ-024 busy SHALL be high in SKIP, SHIFT and DONE, and low in IDLE.
REQ-025 Buffer: FIFO, first-word fall-through; dout_valid = not empty; a pop occurs when dout_valid and dout_ready are both high.
REQ-026 A push into a full buffer without a simultaneous pop SHALL drop the new word, leave contents unchanged and pulse overflow.
REQ-027 A simultaneous push and pop when full SHALL succeed with no overflow; when empty, the push SHALL become visible on dout the following cycle.
REQ-028 Latency: dout_valid SHALL rise 2 clk cycles after the cycle in which the final bit is captured, provided the buffer was empty.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width SHALL be clog2(FIFO_DEPTH)+1.

Reset
REQ-030 On rst: state IDLE, count 0, synchronizers cs=1, sclk=0, mosi=0, buffer empty.
REQ-031 On rst: dout 0, dout_valid 0, busy 0, frame_err 0, overflow 0.
REQ-032 rst mid-frame SHALL abandon the frame without a frame_err pulse; the next frame requires a fresh cs falling edge.

Structure
REQ-033 Package spi_pkg SHALL hold DATA_W default, the FSM state enum typedef and the default FIFO_DEPTH.
REQ-034 The buffer SHALL be a separate sub-module, spi_rx_fifo (parameters DATA_W, FIFO_DEPTH; push/pop/full/empty).

Verification
REQ-035 Frame 12'hA5C with dout_ready=1 -> exactly one dout_valid cycle with dout=12'hA5C; frame_err=0.
REQ-036 Back-to-back frames 12'h001, 12'h800, 12'hFFF -> words emitted in that order; no overflow.
REQ-037 cs deasserted after 5 data bits -> one frame_err pulse, no push; the following frame 12'h3C3 is received correctly.
REQ-038 Five frames with dout_ready=0 -> 4 words buffered, one overflow pulse on the 5th; draining yields words 1-4 in order.
REQ-039 Buffer full with a push in the same cycle as a pop -> no overflow; occupancy stays 4; order is preserved.
REQ-040 rst asserted after 6 bits, then a clean frame 12'h5A5 -> outputs are at reset values, then 12'h5A5 is received; no frame_err.
